// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Pipeline sequencer for the 5-stage core. It sits beside the ID stage and
//   drives the IF/ID hold/flush, ID/EX flush and whole-pipe freeze controls.
//   It detects RAW hazards (load-use only when forwarding is on), kills
//   wrong-path instructions on a taken branch, and freezes the pipe while a
//   multi-cycle SRAM access is outstanding. The SRAM wait is bounded by a
//   timeout that aborts the access and raises a sticky error.
//
//   Ports
//     clk, rst                 clock (rising edge), async active-low reset
//     id_src1/_vld, id_src2/_vld   ID-stage source operands
//     exe_WB_EN, exe_MEM_R_EN, exe_Dest   EXE-stage writeback info
//     mem_WB_EN, mem_Dest      MEM-stage writeback info
//     fwd_en                   forwarding unit enabled
//     branch_taken             EXE-stage branch taken
//     mem_req, sram_ready      MEM-stage SRAM handshake
//     err_clr                  clears timeout_err
//     hold_if, flush_if, flush_id, freeze_all, mem_abort   control outputs
//     timeout_err              sticky SRAM timeout flag
//     haz_cnt, wait_cnt_tot, flush_cnt   saturating performance counters
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_src1,
  input  logic             id_src1_vld,
  input  logic [3:0]       id_src2,
  input  logic             id_src2_vld,
  input  logic             exe_WB_EN,
  input  logic             exe_MEM_R_EN,
  input  logic [3:0]       exe_Dest,
  input  logic             mem_WB_EN,
  input  logic [3:0]       mem_Dest,
  input  logic             fwd_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  input  logic             err_clr,
  output logic             hold_if,
  output logic             flush_if,
  output logic             flush_id,
  output logic             freeze_all,
  output logic             mem_abort,
  output logic             timeout_err,
  output logic [CNT_W-1:0] haz_cnt,
  output logic [CNT_W-1:0] wait_cnt_tot,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ABORT    = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [WCNT_W-1:0] wcnt_reg, wcnt_next;
  logic              timeout_err_reg, timeout_err_next;
  logic              timeout_hit;
  logic              hazard;

  // ---------------------------------------------------------------------------
  // RAW hazard detection. With forwarding, only a load in EXE cannot be
  // bypassed in time; without it, any pending writer in EXE or MEM stalls.
  // ---------------------------------------------------------------------------
  logic exe_hit, mem_hit;

  always_comb begin
    exe_hit = (id_src1_vld && (id_src1 == exe_Dest)) ||
              (id_src2_vld && (id_src2 == exe_Dest));
    mem_hit = (id_src1_vld && (id_src1 == mem_Dest)) ||
              (id_src2_vld && (id_src2 == mem_Dest));
    if (fwd_en) begin
      hazard = exe_MEM_R_EN && exe_WB_EN && exe_hit;
    end else begin
      hazard = (exe_WB_EN && exe_hit) || (mem_WB_EN && mem_hit);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= S_RUN;
      wcnt_reg        <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wcnt_reg        <= wcnt_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. The first frozen cycle happens in RUN, so the
  // wait counter starts at 1 on entry to MEM_WAIT and the abort fires after
  // exactly TIMEOUT frozen cycles.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    wcnt_next   = wcnt_reg;
    timeout_hit = 1'b0;
    case (state_reg)
      S_RUN: begin
        if (mem_req && !sram_ready) begin
          state_next = S_MEM_WAIT;
          wcnt_next  = WCNT_W'(1);
        end
      end
      S_MEM_WAIT: begin
        if (sram_ready) begin
          state_next = S_RUN;
          wcnt_next  = '0;
        end else if (wcnt_reg == WCNT_LAST) begin
          state_next  = S_ABORT;
          wcnt_next   = '0;
          timeout_hit = 1'b1;
        end else begin
          wcnt_next = wcnt_reg + 1'b1;
        end
      end
      S_ABORT: begin
        // The aborted request is dropped regardless of mem_req.
        state_next = S_RUN;
        wcnt_next  = '0;
      end
      default: begin
        state_next = S_RUN;
        wcnt_next  = '0;
      end
    endcase

    // A timeout in the same cycle as a clear keeps the flag set.
    if (timeout_hit) begin
      timeout_err_next = 1'b1;
    end else if (err_clr) begin
      timeout_err_next = 1'b0;
    end else begin
      timeout_err_next = timeout_err_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic. Outputs are combinational so a stall/flush takes
  // effect on the stage registers in the same cycle. They are forced low
  // while reset is asserted, since RUN alone could still raise freeze_all.
  // ---------------------------------------------------------------------------
  always_comb begin
    hold_if    = 1'b0;
    flush_if   = 1'b0;
    flush_id   = 1'b0;
    freeze_all = 1'b0;
    mem_abort  = 1'b0;
    if (rst) begin
      case (state_reg)
        S_RUN:      freeze_all = mem_req && !sram_ready;
        S_MEM_WAIT: freeze_all = !sram_ready;
        S_ABORT:    mem_abort  = 1'b1;
        default:    freeze_all = 1'b0;
      endcase
      // A frozen pipe keeps everything in place; branch and hazard are
      // simply re-evaluated once the freeze lifts.
      if (!freeze_all) begin
        if (branch_taken) begin
          flush_if = 1'b1;
          flush_id = 1'b1;
        end else if (hazard) begin
          hold_if  = 1'b1;
          flush_id = 1'b1;
        end
      end
    end
  end

  assign timeout_err = timeout_err_reg;

  // ---------------------------------------------------------------------------
  // Saturating performance counters: 0 = hazard stalls, 1 = freeze cycles,
  // 2 = branch flushes.
  // ---------------------------------------------------------------------------
  logic [2:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_reg [3];

  assign cnt_inc = {flush_if, freeze_all, hold_if};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign haz_cnt      = cnt_reg[0];
  assign wait_cnt_tot = cnt_reg[1];
  assign flush_cnt    = cnt_reg[2];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (TIMEOUT=8, CNT_W=4 so that
// counter saturation is reachable in a short run).
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       id_src1, id_src2, exe_Dest, mem_Dest;
  logic             id_src1_vld, id_src2_vld;
  logic             exe_WB_EN, exe_MEM_R_EN, mem_WB_EN;
  logic             fwd_en, branch_taken, mem_req, sram_ready, err_clr;
  logic             hold_if, flush_if, flush_id, freeze_all, mem_abort;
  logic             timeout_err;
  logic [CNT_W-1:0] haz_cnt, wait_cnt_tot, flush_cnt;

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src1_vld(id_src1_vld),
    .id_src2(id_src2), .id_src2_vld(id_src2_vld),
    .exe_WB_EN(exe_WB_EN), .exe_MEM_R_EN(exe_MEM_R_EN), .exe_Dest(exe_Dest),
    .mem_WB_EN(mem_WB_EN), .mem_Dest(mem_Dest),
    .fwd_en(fwd_en), .branch_taken(branch_taken),
    .mem_req(mem_req), .sram_ready(sram_ready), .err_clr(err_clr),
    .hold_if(hold_if), .flush_if(flush_if), .flush_id(flush_id),
    .freeze_all(freeze_all), .mem_abort(mem_abort), .timeout_err(timeout_err),
    .haz_cnt(haz_cnt), .wait_cnt_tot(wait_cnt_tot), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Stimulus vector: hazard/branch inputs and expected {hold, flush_if, flush_id}.
  typedef struct {
    logic       fwd;
    logic [3:0] s1;  logic v1;
    logic [3:0] s2;  logic v2;
    logic       ewb; logic emr; logic [3:0] ed;
    logic       mwb; logic [3:0] md;
    logic       br;
    logic       hold; logic fif; logic fid;
  } vec_t;

  // Expected control outputs {hold_if, flush_if, flush_id, freeze_all, mem_abort}.
  typedef logic [4:0] exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q [$];
  vec_t vt [13];

  function automatic vec_t mkv(input logic fwd, input logic [3:0] s1, input logic v1,
                               input logic [3:0] s2, input logic v2,
                               input logic ewb, input logic emr, input logic [3:0] ed,
                               input logic mwb, input logic [3:0] md, input logic br,
                               input logic hold, input logic fif, input logic fid);
    vec_t v;
    v.fwd = fwd; v.s1 = s1; v.v1 = v1; v.s2 = s2; v.v2 = v2;
    v.ewb = ewb; v.emr = emr; v.ed = ed; v.mwb = mwb; v.md = md; v.br = br;
    v.hold = hold; v.fif = fif; v.fid = fid;
    return v;
  endfunction

  task automatic idle();
    id_src1 = 4'd0; id_src1_vld = 1'b0; id_src2 = 4'd0; id_src2_vld = 1'b0;
    exe_WB_EN = 1'b0; exe_MEM_R_EN = 1'b0; exe_Dest = 4'd0;
    mem_WB_EN = 1'b0; mem_Dest = 4'd0; fwd_en = 1'b0; branch_taken = 1'b0;
    mem_req = 1'b0; sram_ready = 1'b0; err_clr = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    fwd_en = v.fwd; id_src1 = v.s1; id_src1_vld = v.v1; id_src2 = v.s2; id_src2_vld = v.v2;
    exe_WB_EN = v.ewb; exe_MEM_R_EN = v.emr; exe_Dest = v.ed;
    mem_WB_EN = v.mwb; mem_Dest = v.md; branch_taken = v.br;
  endtask

  task automatic push_exp(input logic h, input logic fi, input logic fd,
                          input logic fz, input logic ab);
    exp_q.push_back({h, fi, fd, fz, ab});
  endtask

  // Pop one expectation and compare against the outputs at the falling edge.
  task automatic check_outs(input string nm);
    exp_t e, a;
    @(negedge clk);
    a = {hold_if, flush_if, flush_id, freeze_all, mem_abort};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: got hold/fif/fid/frz/abort=%b but no expectation queued", nm, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got hold/fif/fid/frz/abort=%b expected %b", nm, a, e);
      end else begin
        $display("ok   %s: hold/fif/fid/frz/abort=%b", nm, a);
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  // Reset with a pending SRAM miss applied: outputs must still be all zero.
  task automatic do_reset();
    @(posedge clk); #1;
    idle();
    mem_req = 1'b1;
    rst = 1'b0;
    #2;
    chk("rst_ctrl", {hold_if, flush_if, flush_id, freeze_all, mem_abort}, 0);
    chk("rst_cnt", {haz_cnt, wait_cnt_tot, flush_cnt}, 0);
    chk("rst_terr", timeout_err, 0);
    @(posedge clk); #1;
    idle();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_haz, exp_fl;
    rst = 1'b0;
    idle();

    //           fwd  s1    v1    s2    v2    ewb   emr   ed    mwb   md    br    hold  fif   fid
    vt[0]  = mkv(1'b1,4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    vt[1]  = mkv(1'b0,4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1);
    vt[2]  = mkv(1'b1,4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[3]  = mkv(1'b0,4'd7, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    vt[4]  = mkv(1'b1,4'd7, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[5]  = mkv(1'b0,4'd7, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[6]  = mkv(1'b0,4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[7]  = mkv(1'b1,4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    vt[8]  = mkv(1'b0,4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    vt[9]  = mkv(1'b1,4'd1, 1'b1, 4'd12,1'b1, 1'b1, 1'b1, 4'd12,1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    vt[10] = mkv(1'b1,4'd12,1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 4'd12,1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[11] = mkv(1'b0,4'd0, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 4'd4, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0, 1'b1);
    vt[12] = mkv(1'b0,4'd2, 1'b1, 4'd8, 1'b1, 1'b1, 1'b1, 4'd9, 1'b1, 4'd10,1'b0, 1'b0, 1'b0, 1'b0);

    do_reset();

    // ---- table-driven hazard / branch priority ----
    exp_haz = 0;
    exp_fl  = 0;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      apply(vt[i]);
      push_exp(vt[i].hold, vt[i].fif, vt[i].fid, 1'b0, 1'b0);
      check_outs($sformatf("vec%0d", i));
      if (vt[i].hold) exp_haz++;
      if (vt[i].fif)  exp_fl++;
    end
    @(posedge clk); #1;
    idle();
    chk("tbl_haz_cnt", haz_cnt, exp_haz);
    chk("tbl_flush_cnt", flush_cnt, exp_fl);
    chk("tbl_wait_cnt", wait_cnt_tot, 0);

    // ---- branch overrides an active hazard ----
    do_reset();
    @(posedge clk); #1;
    apply(vt[7]);
    push_exp(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_outs("br_over_haz");
    @(posedge clk); #1;
    idle();
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_haz_cnt", haz_cnt, 0);

    // ---- 3-cycle SRAM wait with a hazard pending ----
    do_reset();
    @(posedge clk); #1;
    fwd_en = 1'b0; exe_WB_EN = 1'b1; exe_Dest = 4'd2; id_src1 = 4'd2; id_src1_vld = 1'b1;
    mem_req = 1'b1; sram_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c != 0) begin @(posedge clk); #1; end
      push_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_outs($sformatf("wait_frz%0d", c));
    end
    @(posedge clk); #1;
    sram_ready = 1'b1;
    push_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_outs("wait_release");
    @(posedge clk); #1;
    idle();
    chk("wait_cnt3", wait_cnt_tot, 3);
    chk("wait_haz_cnt", haz_cnt, 1);
    push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_outs("wait_back_run");
    @(posedge clk); #1;
    mem_req = 1'b1; sram_ready = 1'b1;
    push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_outs("run_ready_nofrz");

    // ---- timeout: TIMEOUT frozen cycles, abort pulse, sticky error ----
    do_reset();
    @(posedge clk); #1;
    mem_req = 1'b1; sram_ready = 1'b0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      if (c != 1) begin @(posedge clk); #1; end
      err_clr = (c == TIMEOUT);  // clear colliding with the set must lose
      push_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_outs($sformatf("to_frz%0d", c));
    end
    @(posedge clk); #1;
    err_clr = 1'b0;
    branch_taken = 1'b1;
    push_exp(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check_outs("to_abort");
    chk("to_err_set", timeout_err, 1);
    @(posedge clk); #1;
    idle();
    push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_outs("to_after_abort");
    chk("to_wait_cnt", wait_cnt_tot, TIMEOUT);
    chk("to_flush_cnt", flush_cnt, 1);
    chk("to_err_hold", timeout_err, 1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("to_err_clr", timeout_err, 0);

    // ---- reset asserted mid MEM_WAIT ----
    do_reset();
    @(posedge clk); #1;
    mem_req = 1'b1; sram_ready = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_outs("rw_frz0");
    @(posedge clk); #1;
    push_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_outs("rw_frz1");
    #1 rst = 1'b0;
    #1;
    chk("rw_frz_off", freeze_all, 0);
    chk("rw_no_abort", mem_abort, 0);
    chk("rw_wait_cnt0", wait_cnt_tot, 0);
    sram_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_outs("rw_run_ready");
    chk("rw_no_abort2", mem_abort, 0);
    @(posedge clk); #1;
    sram_ready = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_outs("rw_run_miss");
    @(posedge clk); #1;
    sram_ready = 1'b1;
    push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_outs("rw_wait_ready");
    @(posedge clk); #1;
    idle();
    chk("rw_wait_cnt1", wait_cnt_tot, 1);

    // ---- counter saturation ----
    do_reset();
    @(posedge clk); #1;
    apply(vt[9]);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
    end
    #1;
    idle();
    chk("sat_haz_cnt", haz_cnt, (1 << CNT_W) - 1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
